// File: rtl/core_ex_wbck_ctrl.sv
// Write-back controller: round-robin arbitration of ALU/LSU/MDU results onto the
// single regfile write port, plus a pending-write scoreboard and RAW/WAW hazard flag.
module core_ex_wbck_ctrl #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int RF_NUM  = 32
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               alu_wb_valid,
    output logic               alu_wb_ready,
    input  logic               alu_wb_en,
    input  logic [RFIDX_W-1:0] alu_wb_idx,
    input  logic [XLEN-1:0]    alu_wb_dat,

    input  logic               lsu_wb_valid,
    output logic               lsu_wb_ready,
    input  logic               lsu_wb_en,
    input  logic [RFIDX_W-1:0] lsu_wb_idx,
    input  logic [XLEN-1:0]    lsu_wb_dat,

    input  logic               mdu_wb_valid,
    output logic               mdu_wb_ready,
    input  logic               mdu_wb_en,
    input  logic [RFIDX_W-1:0] mdu_wb_idx,
    input  logic [XLEN-1:0]    mdu_wb_dat,

    output logic               rf_wen,
    output logic [RFIDX_W-1:0] rf_widx,
    output logic [XLEN-1:0]    rf_wdat,

    input  logic               lng_issue_valid,
    input  logic [RFIDX_W-1:0] lng_issue_idx,

    input  logic [RFIDX_W-1:0] chk_src1_idx,
    input  logic [RFIDX_W-1:0] chk_src2_idx,
    input  logic [RFIDX_W-1:0] chk_dest_idx,
    output logic               hazard
);

    // ptr    | meaning
    // P_ALU  | ALU has highest priority this cycle
    // P_LSU  | LSU has highest priority this cycle
    // P_MDU  | MDU has highest priority this cycle
    typedef enum logic [1:0] {
        P_ALU = 2'd0,
        P_LSU = 2'd1,
        P_MDU = 2'd2
    } rr_ptr_t;

    rr_ptr_t            ptr;
    logic [2:0]         req;
    logic [2:0]         gnt;
    logic               win_en;
    logic [RFIDX_W-1:0] win_idx;
    logic [XLEN-1:0]    win_dat;
    logic               rf_lng;
    logic [RF_NUM-1:0]  pend;
    logic [RF_NUM-1:0]  pend_nxt;
    logic               src1_hit;
    logic               src2_hit;
    logic               dest_hit;

    assign req = {mdu_wb_valid, lsu_wb_valid, alu_wb_valid};

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            P_ALU: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            P_LSU: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            default: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
        endcase
    end

    assign alu_wb_ready = gnt[0];
    assign lsu_wb_ready = gnt[1];
    assign mdu_wb_ready = gnt[2];

    always_comb begin
        win_en  = 1'b0;
        win_idx = '0;
        win_dat = '0;
        if (gnt[0]) begin
            win_en  = alu_wb_en;
            win_idx = alu_wb_idx;
            win_dat = alu_wb_dat;
        end else if (gnt[1]) begin
            win_en  = lsu_wb_en;
            win_idx = lsu_wb_idx;
            win_dat = lsu_wb_dat;
        end else if (gnt[2]) begin
            win_en  = mdu_wb_en;
            win_idx = mdu_wb_idx;
            win_dat = mdu_wb_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= P_ALU;
            rf_wen  <= 1'b0;
            rf_widx <= '0;
            rf_wdat <= '0;
            rf_lng  <= 1'b0;
        end else begin
            rf_wen <= (|gnt) && win_en && (win_idx != '0);
            if (|gnt) begin
                rf_widx <= win_idx;
                rf_wdat <= win_dat;
                rf_lng  <= gnt[1] | gnt[2];
            end
            if (gnt[0])      ptr <= P_LSU;
            else if (gnt[1]) ptr <= P_MDU;
            else if (gnt[2]) ptr <= P_ALU;
        end
    end

    // A new long-latency issue to the register being committed must stay pending,
    // so the set is applied after the clear.
    always_comb begin
        pend_nxt = pend;
        if (rf_wen && rf_lng)
            pend_nxt[rf_widx] = 1'b0;
        if (lng_issue_valid && (lng_issue_idx != '0))
            pend_nxt[lng_issue_idx] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    // The rf_wen terms cover the cycle where the write sits in the output register
    // and the regfile has not yet been updated.
    assign src1_hit = (chk_src1_idx != '0) &&
                      (pend[chk_src1_idx] || (rf_wen && (rf_widx == chk_src1_idx)));
    assign src2_hit = (chk_src2_idx != '0) &&
                      (pend[chk_src2_idx] || (rf_wen && (rf_widx == chk_src2_idx)));
    assign dest_hit = (chk_dest_idx != '0) && pend[chk_dest_idx];

    assign hazard = src1_hit | src2_hit | dest_hit;

endmodule

// File: tb/tb_core_ex_wbck_ctrl.sv
// Bench for core_ex_wbck_ctrl: directed vectors, expected regfile writes queued
// by the stimulus and checked by a separate monitor on the write port.
module tb_core_ex_wbck_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wb_valid, alu_wb_ready, alu_wb_en;
    logic [4:0]  alu_wb_idx;
    logic [31:0] alu_wb_dat;
    logic        lsu_wb_valid, lsu_wb_ready, lsu_wb_en;
    logic [4:0]  lsu_wb_idx;
    logic [31:0] lsu_wb_dat;
    logic        mdu_wb_valid, mdu_wb_ready, mdu_wb_en;
    logic [4:0]  mdu_wb_idx;
    logic [31:0] mdu_wb_dat;
    logic        rf_wen;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdat;
    logic        lng_issue_valid;
    logic [4:0]  lng_issue_idx;
    logic [4:0]  chk_src1_idx, chk_src2_idx, chk_dest_idx;
    logic        hazard;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    core_ex_wbck_ctrl #(.XLEN(32), .RFIDX_W(5), .RF_NUM(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_en(alu_wb_en),
        .alu_wb_idx(alu_wb_idx), .alu_wb_dat(alu_wb_dat),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_en(lsu_wb_en),
        .lsu_wb_idx(lsu_wb_idx), .lsu_wb_dat(lsu_wb_dat),
        .mdu_wb_valid(mdu_wb_valid), .mdu_wb_ready(mdu_wb_ready), .mdu_wb_en(mdu_wb_en),
        .mdu_wb_idx(mdu_wb_idx), .mdu_wb_dat(mdu_wb_dat),
        .rf_wen(rf_wen), .rf_widx(rf_widx), .rf_wdat(rf_wdat),
        .lng_issue_valid(lng_issue_valid), .lng_issue_idx(lng_issue_idx),
        .chk_src1_idx(chk_src1_idx), .chk_src2_idx(chk_src2_idx), .chk_dest_idx(chk_dest_idx),
        .hazard(hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] idx, input logic [31:0] dat);
        wr_t w;
        w.idx = idx;
        w.dat = dat;
        exp_q.push_back(w);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        chk_src1_idx = s1;
        chk_src2_idx = s2;
        chk_dest_idx = d;
    endtask

    task automatic check_rdy(input string name, input logic [2:0] exp);
        check(name, {29'd0, mdu_wb_ready, lsu_wb_ready, alu_wb_ready}, {29'd0, exp});
    endtask

    task automatic drive_all(input logic v);
        alu_wb_valid = v; alu_wb_en = 1'b1; alu_wb_idx = 5'd1; alu_wb_dat = 32'hA000_0001;
        lsu_wb_valid = v; lsu_wb_en = 1'b1; lsu_wb_idx = 5'd2; lsu_wb_dat = 32'hB000_0002;
        mdu_wb_valid = v; mdu_wb_en = 1'b1; mdu_wb_idx = 5'd3; mdu_wb_dat = 32'hC000_0003;
    endtask

    // Monitor: every regfile write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_wen !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got idx %0d dat %0h, expected no write", rf_widx, rf_wdat);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wb_idx", {27'd0, rf_widx}, {27'd0, w.idx});
                check("wb_dat", rf_wdat, w.dat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] rr_exp [3];

    initial begin
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rst_n = 1'b0;
        drive_all(1'b0);
        lng_issue_valid = 1'b0; lng_issue_idx = '0;
        set_chk(5'd5, 5'd7, 5'd0);

        // reset and idle
        next_cyc();
        @(negedge clk);
        check("rst_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_widx", {27'd0, rf_widx}, 32'd0);
        check("rst_wdat", rf_wdat, 32'd0);
        check_rdy("rst_ready", 3'b000);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        set_chk(5'd0, 5'd0, 5'd31);
        #1 check("rst_hazard_dest", {31'd0, hazard}, 32'd0);
        next_cyc();
        rst_n = 1'b1;

        // round robin under contention, pointer starts at ALU
        drive_all(1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_rdy("rr_ready", rr_exp[k % 3]);
            case (k % 3)
                0: push(5'd1, 32'hA000_0001);
                1: push(5'd2, 32'hB000_0002);
                default: push(5'd3, 32'hC000_0003);
            endcase
            next_cyc();
        end
        drive_all(1'b0);

        // single ALU write
        alu_wb_valid = 1'b1; alu_wb_en = 1'b1; alu_wb_idx = 5'd5; alu_wb_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        check_rdy("alu_ready", 3'b001);
        push(5'd5, 32'hDEAD_BEEF);
        next_cyc();
        alu_wb_valid = 1'b0;
        set_chk(5'd5, 5'd0, 5'd0);
        @(negedge clk);
        check("alu_wen_n1", {31'd0, rf_wen}, 32'd1);
        check("alu_widx_n1", {27'd0, rf_widx}, 32'd5);
        check("alu_wdat_n1", rf_wdat, 32'hDEAD_BEEF);
        check("fwd_src1_hazard", {31'd0, hazard}, 32'd1);
        set_chk(5'd0, 5'd0, 5'd5);
        #1 check("fwd_dest_no_hazard", {31'd0, hazard}, 32'd0);
        set_chk(5'd0, 5'd5, 5'd0);
        #1 check("fwd_src2_hazard", {31'd0, hazard}, 32'd1);
        next_cyc();
        @(negedge clk);
        check("alu_wen_n2", {31'd0, rf_wen}, 32'd0);

        // scoreboard set on issue, clear after LSU commit
        next_cyc();
        set_chk(5'd7, 5'd0, 5'd0);
        lng_issue_valid = 1'b1; lng_issue_idx = 5'd7;
        @(negedge clk);
        check("pend7_same_cycle", {31'd0, hazard}, 32'd0);
        next_cyc();
        lng_issue_valid = 1'b0;
        @(negedge clk);
        check("pend7_set", {31'd0, hazard}, 32'd1);
        next_cyc();
        lsu_wb_valid = 1'b1; lsu_wb_en = 1'b1; lsu_wb_idx = 5'd7; lsu_wb_dat = 32'h0000_0777;
        @(negedge clk);
        check_rdy("lsu_ready", 3'b010);
        check("pend7_at_hs", {31'd0, hazard}, 32'd1);
        push(5'd7, 32'h0000_0777);
        next_cyc();
        lsu_wb_valid = 1'b0;
        set_chk(5'd0, 5'd0, 5'd7);
        @(negedge clk);
        check("pend7_commit", {31'd0, hazard}, 32'd1);
        next_cyc();
        @(negedge clk);
        check("pend7_cleared_dest", {31'd0, hazard}, 32'd0);
        set_chk(5'd7, 5'd7, 5'd7);
        #1 check("pend7_cleared_all", {31'd0, hazard}, 32'd0);

        // set/clear collision on idx 9, then ALU write must not clear it
        next_cyc();
        lng_issue_valid = 1'b1; lng_issue_idx = 5'd9;
        next_cyc();
        lng_issue_valid = 1'b0;
        mdu_wb_valid = 1'b1; mdu_wb_en = 1'b1; mdu_wb_idx = 5'd9; mdu_wb_dat = 32'h0000_0099;
        set_chk(5'd0, 5'd0, 5'd9);
        @(negedge clk);
        check_rdy("mdu_ready", 3'b100);
        check("pend9_set", {31'd0, hazard}, 32'd1);
        push(5'd9, 32'h0000_0099);
        next_cyc();
        mdu_wb_valid = 1'b0;
        lng_issue_valid = 1'b1; lng_issue_idx = 5'd9;
        @(negedge clk);
        check("mdu_commit_wen", {31'd0, rf_wen}, 32'd1);
        next_cyc();
        lng_issue_valid = 1'b0;
        @(negedge clk);
        check("collision_set_wins", {31'd0, hazard}, 32'd1);
        next_cyc();
        alu_wb_valid = 1'b1; alu_wb_en = 1'b1; alu_wb_idx = 5'd9; alu_wb_dat = 32'h0000_1234;
        @(negedge clk);
        check_rdy("alu9_ready", 3'b001);
        push(5'd9, 32'h0000_1234);
        next_cyc();
        alu_wb_valid = 1'b0;
        next_cyc();
        @(negedge clk);
        check("alu_no_clear", {31'd0, hazard}, 32'd1);

        // x0 write and en=0 handshake; pointer is at LSU here
        next_cyc();
        set_chk(5'd0, 5'd0, 5'd0);
        alu_wb_valid = 1'b1; alu_wb_en = 1'b1; alu_wb_idx = 5'd0; alu_wb_dat = 32'h0000_AAAA;
        @(negedge clk);
        check_rdy("x0_ready", 3'b001);
        check("x0_hazard", {31'd0, hazard}, 32'd0);
        next_cyc();
        alu_wb_valid = 1'b0;
        lsu_wb_valid = 1'b1; lsu_wb_en = 1'b0; lsu_wb_idx = 5'd4; lsu_wb_dat = 32'h0000_4444;
        @(negedge clk);
        check_rdy("en0_ready", 3'b010);
        check("x0_no_wen", {31'd0, rf_wen}, 32'd0);
        next_cyc();
        lsu_wb_valid = 1'b0;
        set_chk(5'd4, 5'd0, 5'd4);
        @(negedge clk);
        check("en0_no_wen", {31'd0, rf_wen}, 32'd0);
        check("en0_no_pend", {31'd0, hazard}, 32'd0);
        next_cyc();
        drive_all(1'b1);
        @(negedge clk);
        check_rdy("ptr_after_x0_en0", 3'b100);
        push(5'd3, 32'hC000_0003);
        next_cyc();
        drive_all(1'b0);

        // reset mid-operation: pend and in-flight write dropped, pointer back to ALU
        lng_issue_valid = 1'b1; lng_issue_idx = 5'd12;
        next_cyc();
        lng_issue_valid = 1'b0;
        lsu_wb_valid = 1'b1; lsu_wb_en = 1'b1; lsu_wb_idx = 5'd13; lsu_wb_dat = 32'h0000_1313;
        rst_n = 1'b0;
        @(negedge clk);
        check_rdy("rst_mid_ready", 3'b010);
        next_cyc();
        lsu_wb_valid = 1'b0;
        rst_n = 1'b1;
        set_chk(5'd12, 5'd13, 5'd12);
        @(negedge clk);
        check("rst_mid_wen", {31'd0, rf_wen}, 32'd0);
        check("rst_mid_pend", {31'd0, hazard}, 32'd0);
        next_cyc();
        drive_all(1'b1);
        @(negedge clk);
        check_rdy("rst_mid_ptr", 3'b001);
        push(5'd1, 32'hA000_0001);
        next_cyc();
        drive_all(1'b0);

        repeat (3) next_cyc();
        check("exp_queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ex_wbck_ctrl.md
Name: core_ex_wbck_ctrl

Overview:
- Shares the single register-file write port (wb_dest_wen / wb_dest_idx / wb_dest_dat) between three execute-stage producers: ALU, LSU and MDU.
- Round-robin arbitration with valid/ready handshakes; the winning write is registered for one cycle before it reaches the regfile.
- Holds a pending-write scoreboard for long-latency (LSU/MDU) destinations and drives a combinational RAW/WAW hazard flag to the issue logic.

Parameters:
XLEN, 32, data width (matches CORE_XLEN)
RFIDX_W, 5, register index width (matches CORE_RFIDX_WIDTH)
RF_NUM, 32, number of architectural registers

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
alu_wb_valid  input  1  ALU result available
alu_wb_ready  output  1  ALU grant; handshake when valid&ready
alu_wb_en  input  1  1 = result writes rd, 0 = handshake only (branch/store)
alu_wb_idx  input  RFIDX_W  ALU destination index
alu_wb_dat  input  XLEN  ALU result
lsu_wb_valid / lsu_wb_ready / lsu_wb_en / lsu_wb_idx / lsu_wb_dat  as ALU, for LSU
mdu_wb_valid / mdu_wb_ready / mdu_wb_en / mdu_wb_idx / mdu_wb_dat  as ALU, for MDU
rf_wen  output  1  to regfile wb_dest_wen (registered)
rf_widx  output  RFIDX_W  to regfile wb_dest_idx (registered)
rf_wdat  output  XLEN  to regfile wb_dest_dat (registered)
lng_issue_valid  input  1  a long-latency op with rd is dispatched this cycle
lng_issue_idx  input  RFIDX_W  its destination index
chk_src1_idx  input  RFIDX_W  issuing instruction rs1
chk_src2_idx  input  RFIDX_W  issuing instruction rs2
chk_dest_idx  input  RFIDX_W  issuing instruction rd
hazard  output  1  combinational: issue must stall

Behaviour:
- Reset (rst_n=0 at a clock edge): rf_wen=0, rf_widx=0, rf_wdat=0, rr pointer=ALU, all pending bits=0. Reset mid-operation drops any in-flight registered write and all pending marks.
- Arbitration:
  - At most one grant per cycle.
  - Request order starts at the pointer, cycling ALU->LSU->MDU->ALU. The first valid requester is granted, and its ready is driven high combinationally in the same cycle.
  - After a grant, the pointer moves to the requester following the winner. With no grant, the pointer holds.
  - readys are 0 for non-winners and whenever no valid is asserted.
- Requester rule: once valid is raised, valid, en, idx and dat hold stable until the handshake. The block does not check this.
- Write register, updated every cycle:
  - rf_wen <= grant & en & (idx!=0).
  - rf_widx and rf_wdat load the winner's idx/dat on grant; otherwise they hold.
  - Latency: handshake in cycle N -> rf_wen high in cycle N+1 -> regfile updated at end of N+1.
  - Fully pipelined, so back-to-back grants yield back-to-back writes.
- Scoreboard pend[RF_NUM-1:0]; pend[0] is constant 0.
  - Set: lng_issue_valid & lng_issue_idx!=0 sets pend[lng_issue_idx].
  - Clear: at the end of a cycle where rf_wen=1 and the registered write came from LSU or MDU, clear pend[rf_widx]. Track the source in a 1-bit registered flag.
  - Set and clear on the same index in the same cycle: set wins.
  - ALU writes never clear pend.
  - LSU/MDU handshakes with en=0 clear nothing. Issue logic never sets pend for such ops.
- hazard is asserted when any of the following holds (each idx term is suppressed when that idx==0):
  - pend[chk_src1_idx], pend[chk_src2_idx] or pend[chk_dest_idx] is set;
  - rf_wen & rf_widx==chk_src1_idx;
  - rf_wen & rf_widx==chk_src2_idx.
  The last two cover the cycle before the regfile commit.
- Writes to x0 never assert rf_wen but still handshake and advance the pointer.

Test Plan:
- Reset then idle: after rst_n low for 1 cycle -> rf_wen=0, rf_widx=0, rf_wdat=0, all readys 0, hazard=0 for any chk idx.
- Single ALU write: alu valid, en=1, idx=5, dat=0xDEADBEEF in cycle N -> alu_wb_ready=1 in N; rf_wen=1, rf_widx=5, rf_wdat=0xDEADBEEF in N+1; rf_wen=0 in N+2.
- Round-robin under contention: all three valid continuously from reset with idx 1/2/3 -> grants ALU, LSU, MDU, ALU... and rf_widx sequence 1,2,3,1 on consecutive cycles.
- Scoreboard:
  - lng_issue idx=7 in cycle N -> hazard=1 with chk_src1=7 from N+1.
  - LSU handshake idx=7 in M -> hazard stays 1 in M+1 (commit cycle), 0 in M+2.
- Set/clear collision: commit of MDU write to idx=9 in the same cycle as lng_issue idx=9 -> pend[9] remains 1, hazard with chk_dest=9 stays 1.
- x0 and en=0: ALU valid idx=0 en=1, then LSU valid idx=4 en=0 -> both get ready; rf_wen stays 0; pointer advances; hazard never asserted for chk idx 0.
